// File: rtl/kinase_fluid_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : kinase_fluid_sequencer_if
// Description : Host command / status bundle for the kinase fluid sequencer.
//               The host is the master; the sequencer is the slave.
// Revision    : 1.0  initial release
// ============================================================================
interface kinase_fluid_sequencer_if #(
  parameter int STROKE_W = 8
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_in_sel;
  logic [1:0]          cmd_out_sel;
  logic [STROKE_W-1:0] cmd_load;
  logic [STROKE_W-1:0] cmd_mix;
  logic                abort;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output cmd_valid, cmd_in_sel, cmd_out_sel, cmd_load, cmd_mix, abort,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_in_sel, cmd_out_sel, cmd_load, cmd_mix, abort,
    output cmd_ready, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/kinase_fluid_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : kinase_fluid_sequencer
// Description : Runs one kinase-activity sequence: inlet -> load -> mix ->
//               outlet drain -> flush. Valve outputs are 1 = closed.
//               Every output is registered from the next-state decode, so the
//               valve pattern of a stage appears in the first cycle of it.
// Revision    : 1.0  initial release
// ============================================================================
module kinase_fluid_sequencer #(
  parameter int PHASE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int FLUSH_CYCLES  = 16,
  parameter int STROKE_W      = 8
) (
  input  wire                      clk,
  input  wire                      rst_n,
  kinase_fluid_sequencer_if.slave  cmd,
  output logic [12:0]              ctrl_a,
  output logic [3:0]               ctrl_s,
  output logic [2:0]               pump_a,
  output logic [1:0]               pump_b,
  output logic [12:0]              flush_ctrl_a,
  output logic [3:0]               flush_ctrl_s,
  output logic [2:0]               flush_pump_a,
  output logic [1:0]               flush_pump_b
);

  localparam int CNT_MAX0 = (PHASE_CYCLES > SETTLE_CYCLES) ? PHASE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > FLUSH_CYCLES) ? CNT_MAX0 : FLUSH_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [STROKE_W-1:0] ONE_STROKE = STROKE_W'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SET_IN  = 4'd1,
    S_LOAD    = 4'd2,
    S_SET_MIX = 4'd3,
    S_MIX     = 4'd4,
    S_SET_OUT = 4'd5,
    S_DRAIN   = 4'd6,
    S_FLUSH   = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [2:0]          step, step_nx;
  logic [STROKE_W-1:0] stroke, stroke_nx;
  logic                aborted, aborted_nx;
  logic [1:0]          in_sel, in_sel_nx, out_sel, out_sel_nx;
  logic [STROKE_W-1:0] load, load_nx, mix, mix_nx;
  logic                err_nx;
  logic [STROKE_W-1:0] stroke_last;
  logic [2:0]          step_last;
  logic [12:0]         ctrl_a_nx;
  logic [3:0]          ctrl_s_nx;
  logic [2:0]          pump_a_nx;
  logic [1:0]          pump_b_nx;
  logic                flush_nx;

  // Three-phase peristaltic sequence, one entry per pump_a step.
  function automatic logic [2:0] pa_pattern(input logic [2:0] s);
    case (s)
      3'd0:    pa_pattern = 3'b011;
      3'd1:    pa_pattern = 3'b001;
      3'd2:    pa_pattern = 3'b101;
      3'd3:    pa_pattern = 3'b100;
      3'd4:    pa_pattern = 3'b110;
      3'd5:    pa_pattern = 3'b010;
      default: pa_pattern = 3'b111;
    endcase
  endfunction

  // State, timing counters and captured command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      step    <= '0;
      stroke  <= '0;
      aborted <= 1'b0;
      in_sel  <= '0;
      out_sel <= '0;
      load    <= '0;
      mix     <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      step    <= step_nx;
      stroke  <= stroke_nx;
      aborted <= aborted_nx;
      in_sel  <= in_sel_nx;
      out_sel <= out_sel_nx;
      load    <= load_nx;
      mix     <= mix_nx;
    end
  end

  // Next-state sequencing and next-cycle valve/pump decode.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    step_nx     = step;
    stroke_nx   = stroke;
    aborted_nx  = aborted;
    in_sel_nx   = in_sel;
    out_sel_nx  = out_sel;
    load_nx     = load;
    mix_nx      = mix;
    err_nx      = 1'b0;
    stroke_last = ((state == S_MIX) ? mix : load) - ONE_STROKE;
    step_last   = (state == S_MIX) ? 3'd1 : 3'd5;

    unique case (state)
      S_IDLE: begin
        // abort is deliberately not looked at here: a command always wins
        if (cmd.cmd_valid) begin
          in_sel_nx  = cmd.cmd_in_sel;
          out_sel_nx = cmd.cmd_out_sel;
          load_nx    = cmd.cmd_load;
          mix_nx     = cmd.cmd_mix;
          cnt_nx     = '0;
          aborted_nx = 1'b0;
          if (cmd.cmd_in_sel == 2'd3) err_nx = 1'b1;
          else                        state_nx = S_SET_IN;
        end
      end
      S_SET_IN, S_SET_MIX, S_SET_OUT: begin
        if (cmd.abort) begin
          state_nx   = S_FLUSH;
          cnt_nx     = '0;
          aborted_nx = 1'b1;
        end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_nx    = '0;
          step_nx   = '0;
          stroke_nx = '0;
          // a zero stroke count skips the pump stage entirely
          if (state == S_SET_IN)       state_nx = (load == '0) ? S_SET_MIX : S_LOAD;
          else if (state == S_SET_MIX) state_nx = (mix == '0) ? S_SET_OUT : S_MIX;
          else                         state_nx = (load == '0) ? S_FLUSH : S_DRAIN;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_LOAD, S_MIX, S_DRAIN: begin
        if (cmd.abort) begin
          state_nx   = S_FLUSH;
          cnt_nx     = '0;
          aborted_nx = 1'b1;
        end else if (cnt == CNT_W'(PHASE_CYCLES - 1)) begin
          cnt_nx = '0;
          if (step == step_last) begin
            step_nx = '0;
            // terminate on equality with count-1 so a full-scale count never wraps
            if (stroke == stroke_last) begin
              stroke_nx = '0;
              if (state == S_LOAD)     state_nx = S_SET_MIX;
              else if (state == S_MIX) state_nx = S_SET_OUT;
              else                     state_nx = S_FLUSH;
            end else begin
              stroke_nx = stroke + ONE_STROKE;
            end
          end else begin
            step_nx = step + 3'd1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
          cnt_nx = '0;
          if (aborted) begin
            state_nx   = S_IDLE;
            aborted_nx = 1'b0;
            err_nx     = 1'b1;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    ctrl_a_nx = '1;
    ctrl_s_nx = '1;
    pump_a_nx = 3'b111;
    pump_b_nx = 2'b11;
    flush_nx  = 1'b0;
    case (state_nx)
      S_SET_IN:  ctrl_a_nx[{2'b00, in_sel_nx}] = 1'b0;
      S_LOAD: begin
        ctrl_a_nx[{2'b00, in_sel_nx}] = 1'b0;
        pump_a_nx = pa_pattern(step_nx);
      end
      S_SET_MIX: ctrl_a_nx[12:3] = '0;
      S_MIX: begin
        ctrl_a_nx[12:3] = '0;
        pump_b_nx = step_nx[0] ? 2'b10 : 2'b01;
      end
      S_SET_OUT: ctrl_s_nx[out_sel_nx] = 1'b0;
      S_DRAIN: begin
        ctrl_s_nx[out_sel_nx] = 1'b0;
        pump_a_nx = pa_pattern(step_nx);
      end
      S_FLUSH:   flush_nx = 1'b1;
      default:   ;
    endcase
  end

  // Output registers; reset leaves every line pressurised and flush off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_a        <= '1;
      ctrl_s        <= '1;
      pump_a        <= 3'b111;
      pump_b        <= 2'b11;
      flush_ctrl_a  <= '0;
      flush_ctrl_s  <= '0;
      flush_pump_a  <= '0;
      flush_pump_b  <= '0;
      cmd.cmd_ready <= 1'b1;
      cmd.busy      <= 1'b0;
      cmd.done      <= 1'b0;
      cmd.err       <= 1'b0;
    end else begin
      ctrl_a        <= ctrl_a_nx;
      ctrl_s        <= ctrl_s_nx;
      pump_a        <= pump_a_nx;
      pump_b        <= pump_b_nx;
      flush_ctrl_a  <= {13{flush_nx}};
      flush_ctrl_s  <= {4{flush_nx}};
      flush_pump_a  <= {3{flush_nx}};
      flush_pump_b  <= {2{flush_nx}};
      cmd.cmd_ready <= (state_nx == S_IDLE);
      cmd.busy      <= (state_nx != S_IDLE);
      cmd.done      <= (state_nx == S_DONE);
      cmd.err       <= err_nx;
    end
  end

endmodule
`default_nettype wire
